// File: rtl/pkg_entrada_dados.sv
// rtl/pkg_entrada_dados.sv - State encodings and defaults for the input-capture unit
package pkg_entrada_dados;

    typedef logic [1:0] estado_t;

    localparam estado_t OCIOSO         = 2'b00;
    localparam estado_t ESPERA_PRESSAO = 2'b01;
    localparam estado_t ESPERA_SOLTURA = 2'b10;
    localparam estado_t CONCLUIDO      = 2'b11;

    localparam int DEBOUNCE_PADRAO = 50000;

endpackage

// File: rtl/filtro_botao.sv
// rtl/filtro_botao.sv - Pushbutton synchronizer and debounce filter with edge pulses
module filtro_botao
    import pkg_entrada_dados::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
    input  logic clock,
    input  logic reset_n,
    input  logic botao,
    output logic botao_limpo,
    output logic borda_subida,
    output logic borda_descida
);

    localparam int LARGURA_CONT = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [LARGURA_CONT-1:0] ULTIMO = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);

    logic                    sinc_1;
    logic                    sinc_2;
    logic [LARGURA_CONT-1:0] contador;
    logic                    troca;

    // The pulse is combinational so the FSM moves on the same edge the level toggles.
    assign troca         = (sinc_2 != botao_limpo) && (contador == ULTIMO);
    assign borda_subida  = troca && sinc_2;
    assign borda_descida = troca && !sinc_2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sinc_1      <= 1'b0;
            sinc_2      <= 1'b0;
            botao_limpo <= 1'b0;
            contador    <= '0;
        end else begin
            sinc_1 <= botao;
            sinc_2 <= sinc_1;
            if ((sinc_2 == botao_limpo) || troca) begin
                contador <= '0;
            end else begin
                contador <= contador + 1'b1;
            end
            if (troca) begin
                botao_limpo <= sinc_2;
            end
        end
    end

endmodule

// File: rtl/unidade_entrada_dados.sv
// rtl/unidade_entrada_dados.sv - Stalls an input instruction until a confirmed switch capture
module unidade_entrada_dados
    import pkg_entrada_dados::*;
#(
    parameter int LARGURA_CHAVES  = 16,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [LARGURA_CHAVES-1:0] chaves,
    input  logic                      botao_confirma,
    input  logic                      ctrl_entrada,
    output logic [31:0]               entrada_dados,
    output logic                      pausa,
    output logic                      dado_valido
);

    logic [LARGURA_CHAVES-1:0] chaves_1;
    logic [LARGURA_CHAVES-1:0] chaves_2;
    logic [LARGURA_CHAVES-1:0] captura;
    estado_t                   estado;
    estado_t                   proximo;
    logic                      carrega;
    logic                      botao_limpo;
    logic                      borda_subida;
    logic                      borda_descida;
    logic                      nivel_unused;

    filtro_botao #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_filtro_botao (
        .clock        (clock),
        .reset_n      (reset_n),
        .botao        (botao_confirma),
        .botao_limpo  (botao_limpo),
        .borda_subida (borda_subida),
        .borda_descida(borda_descida)
    );

    // Only the edges drive the FSM; the steady level is not needed here.
    assign nivel_unused = botao_limpo;

    always_comb begin
        proximo = estado;
        carrega = 1'b0;
        case (estado)
            OCIOSO: begin
                if (ctrl_entrada) proximo = ESPERA_PRESSAO;
            end
            ESPERA_PRESSAO: begin
                if (borda_subida) begin
                    proximo = ESPERA_SOLTURA;
                    carrega = 1'b1;
                end else if (!ctrl_entrada) begin
                    proximo = OCIOSO;
                end
            end
            ESPERA_SOLTURA: begin
                if (borda_descida) proximo = CONCLUIDO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chaves_1 <= '0;
            chaves_2 <= '0;
            captura  <= '0;
            estado   <= OCIOSO;
        end else begin
            chaves_1 <= chaves;
            chaves_2 <= chaves_1;
            estado   <= proximo;
            if (carrega) captura <= chaves_2;
        end
    end

    assign entrada_dados = 32'(captura);
    assign pausa         = ((estado == OCIOSO) && ctrl_entrada)
                         || (estado == ESPERA_PRESSAO) || (estado == ESPERA_SOLTURA);
    assign dado_valido   = (estado == CONCLUIDO);

endmodule

// File: tb/tb_unidade_entrada_dados.sv
// tb/tb_unidade_entrada_dados.sv - Table, directed and randomized checks against a reference model
module tb_unidade_entrada_dados;

    localparam int D = 4;

    logic        clock;
    logic        reset_n;
    logic [15:0] chaves;
    logic        botao_confirma;
    logic        ctrl_entrada;
    logic [31:0] entrada_dados;
    logic        pausa;
    logic        dado_valido;

    unidade_entrada_dados #(
        .LARGURA_CHAVES (16),
        .DEBOUNCE_CICLOS(D)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .chaves        (chaves),
        .botao_confirma(botao_confirma),
        .ctrl_entrada  (ctrl_entrada),
        .entrada_dados (entrada_dados),
        .pausa         (pausa),
        .dado_valido   (dado_valido)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int n_pulsos = 0;
    int n_pausa_baixa = 0;

    // Reference model: phase 0 idle, 1 awaiting press, 2 awaiting release, 3 done.
    logic [15:0] m_sw[2];
    bit          m_bt[2];
    bit          m_limpo;
    bit          hist[$];
    int          m_fase;
    logic [15:0] m_cap;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nome, atual, esperado);
        end
    endtask

    task automatic modelo_reset();
        m_sw[0] = '0; m_sw[1] = '0;
        m_bt[0] = 0;  m_bt[1] = 0;
        m_limpo = 0;
        hist.delete();
        m_fase = 0;
        m_cap = '0;
    endtask

    task automatic modelo_borda(input bit c, input logic [15:0] ch, input bit b);
        bit sub, desc, todos;
        sub = 0; desc = 0;
        hist.push_back(m_bt[1]);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            todos = 1;
            foreach (hist[i]) if (hist[i] == m_limpo) todos = 0;
            if (todos) begin
                m_limpo = !m_limpo;
                sub = m_limpo;
                desc = !m_limpo;
                hist.delete();
            end
        end
        case (m_fase)
            0: if (c) m_fase = 1;
            1: if (sub) begin m_cap = m_sw[1]; m_fase = 2; end
               else if (!c) m_fase = 0;
            2: if (desc) m_fase = 3;
            default: m_fase = 0;
        endcase
        m_bt[1] = m_bt[0]; m_bt[0] = b;
        m_sw[1] = m_sw[0]; m_sw[0] = ch;
    endtask

    task automatic passo(input bit c, input bit b, input logic [15:0] ch);
        bit exp_pausa;
        ctrl_entrada = c; botao_confirma = b; chaves = ch;
        @(posedge clock);
        modelo_borda(c, ch, b);
        @(negedge clock);
        exp_pausa = (m_fase == 0 && c) || m_fase == 1 || m_fase == 2;
        check("pausa", {31'b0, pausa}, {31'b0, exp_pausa});
        check("dado_valido", {31'b0, dado_valido}, {31'b0, m_fase == 3});
        check("entrada_dados", entrada_dados, {16'b0, m_cap});
        if (dado_valido) n_pulsos++;
        if (!pausa) n_pausa_baixa++;
    endtask

    task automatic segmento(input bit c, input bit b, input logic [15:0] ch, input int n);
        for (int k = 0; k < n; k++) passo(c, b, ch);
    endtask

    typedef struct {
        bit          ctrl;
        bit          botao;
        logic [15:0] chaves;
        int          ciclos;
        bit          exp_pausa;
        int          exp_pulsos;
        logic [31:0] exp_dados;
    } vetor_t;

    vetor_t tabela[5];

    initial begin
        int espera;

        tabela[0] = '{1, 0, 16'hA5C3, 3,  1, 0, 32'h0000_0000};
        tabela[1] = '{1, 1, 16'hA5C3, 20, 1, 0, 32'h0000_A5C3};
        tabela[2] = '{1, 0, 16'hA5C3, 5,  1, 0, 32'h0000_A5C3};
        tabela[3] = '{1, 0, 16'hA5C3, 1,  0, 1, 32'h0000_A5C3};
        tabela[4] = '{0, 0, 16'hA5C3, 3,  0, 0, 32'h0000_A5C3};

        reset_n = 0; ctrl_entrada = 0; botao_confirma = 0; chaves = '0;
        modelo_reset();
        repeat (2) @(negedge clock);
        check("reset_dados", entrada_dados, 32'h0);
        check("reset_valido", {31'b0, dado_valido}, 32'h0);
        check("reset_pausa0", {31'b0, pausa}, 32'h0);
        ctrl_entrada = 1; #1;
        check("reset_pausa1", {31'b0, pausa}, 32'h1);
        ctrl_entrada = 0;
        @(negedge clock);
        reset_n = 1;

        // Basic capture from the table
        foreach (tabela[i]) begin
            n_pulsos = 0;
            segmento(tabela[i].ctrl, tabela[i].botao, tabela[i].chaves, tabela[i].ciclos);
            check($sformatf("tab%0d_pausa", i), {31'b0, pausa}, {31'b0, tabela[i].exp_pausa});
            check($sformatf("tab%0d_pulsos", i), n_pulsos, tabela[i].exp_pulsos);
            check($sformatf("tab%0d_dados", i), entrada_dados, tabela[i].exp_dados);
        end

        // Asynchronous reset while waiting for release
        segmento(1, 0, 16'h1234, 4);
        segmento(1, 1, 16'h1234, 8);
        segmento(1, 0, 16'h1234, 3);
        @(posedge clock); #3;
        reset_n = 0; #1;
        check("areset_dados", entrada_dados, 32'h0);
        check("areset_valido", {31'b0, dado_valido}, 32'h0);
        check("areset_pausa1", {31'b0, pausa}, 32'h1);
        ctrl_entrada = 0; botao_confirma = 0; #1;
        check("areset_pausa0", {31'b0, pausa}, 32'h0);
        @(negedge clock);
        reset_n = 1;
        modelo_reset();
        n_pulsos = 0;
        segmento(0, 0, 16'h1234, 8);
        check("areset_sem_pulso", n_pulsos, 0);

        // Button already held when the instruction arrives
        segmento(0, 1, 16'hBEEF, 8);
        segmento(1, 1, 16'hBEEF, 12);
        check("held_sem_captura", entrada_dados, 32'h0);
        segmento(1, 0, 16'hBEEF, 8);
        check("held_solto", entrada_dados, 32'h0);
        segmento(1, 1, 16'hBEEF, 8);
        check("held_captura", entrada_dados, 32'h0000_BEEF);
        n_pulsos = 0;
        segmento(0, 0, 16'hBEEF, 8);
        check("held_pulso", n_pulsos, 1);

        // Switches changing after the press edge
        segmento(1, 0, 16'h0001, 3);
        segmento(1, 1, 16'h0001, 8);
        segmento(1, 1, 16'hFFFF, 6);
        check("chaves_mudam", entrada_dados, 32'h0000_0001);
        n_pulsos = 0;
        segmento(0, 0, 16'hFFFF, 8);
        check("chaves_pulso", n_pulsos, 1);
        check("chaves_final", entrada_dados, 32'h0000_0001);

        // Flush while awaiting the press
        n_pulsos = 0;
        segmento(1, 0, 16'h5555, 3);
        check("flush_pausa1", {31'b0, pausa}, 32'h1);
        passo(0, 0, 16'h5555);
        check("flush_pausa0", {31'b0, pausa}, 32'h0);
        segmento(0, 0, 16'h5555, 3);
        check("flush_dados", entrada_dados, 32'h0000_0001);
        check("flush_pulsos", n_pulsos, 0);

        // Back-to-back input instructions
        n_pulsos = 0; n_pausa_baixa = 0;
        segmento(1, 0, 16'h1111, 2);
        segmento(1, 1, 16'h1111, 8);
        segmento(1, 0, 16'h2222, 6);
        segmento(1, 1, 16'h2222, 8);
        segmento(1, 0, 16'h2222, 8);
        check("b2b_pulsos", n_pulsos, 2);
        check("b2b_pausa_baixa", n_pausa_baixa, 2);
        check("b2b_dados", entrada_dados, 32'h0000_2222);
        segmento(0, 0, 16'h2222, 2);

        // Bouncing button, then held
        n_pulsos = 0;
        for (int i = 0; i < 30; i++) passo(1, ((i / 2) % 2) == 1, 16'hABCD);
        check("bounce_sem_pulso", n_pulsos, 0);
        check("bounce_sem_captura", entrada_dados, 32'h0000_2222);
        espera = 0;
        while (entrada_dados !== 32'h0000_ABCD && espera < 20) begin
            passo(1, 1, 16'hABCD);
            espera++;
        end
        check("bounce_latencia", espera, 2 + D);
        segmento(1, 1, 16'hABCD, 4);
        segmento(0, 0, 16'hABCD, 8);
        check("bounce_pulso", n_pulsos, 1);

        // Randomized segments against the model
        for (int s = 0; s < 300; s++) begin
            segmento($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     16'($urandom), $urandom_range(1, 9));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_entrada_dados.md
# unidade_entrada_dados

Input-capture unit feeding the `entrada_dados` operand of the register-bank write-back multiplexer. When the control unit decodes an input instruction, this block stalls the CPU and waits for the user to confirm with a debounced pushbutton. It then latches the synchronized board switches and releases the stall so the instruction completes with the captured value.

## Interface
- `LARGURA_CHAVES`, 16: switch count; 1..32.
- `DEBOUNCE_CICLOS`, 50000: consecutive stable cycles required to accept a button level change; ≥1.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  reset; asynchronous assertion, active-low.
- `chaves`  in  LARGURA_CHAVES  raw, asynchronous board switches.
- `botao_confirma`  in  1  raw, asynchronous pushbutton; active-high (pressed = 1).
- `ctrl_entrada`  in  1  from control unit (UC); high while the current instruction is an input instruction.
- `entrada_dados`  out  32  captured switch value, zero-extended to 32 bits; goes to the write-back mux, select 2'b11.
- `pausa`  out  1  stall request to the UC/PC; while high, the PC and register writes are frozen.
- `dado_valido`  out  1  one-cycle pulse; `entrada_dados` is fresh and the instruction may commit.

## Operation
- Synchronizers:
  - `chaves` passes through a 2-FF synchronizer.
  - `botao_confirma` passes through a 2-FF synchronizer, then the debounce filter.
- Debounce filter:
  - Keeps a registered level `botao_limpo` and a counter.
  - Counter clears whenever the synchronized button equals `botao_limpo`, otherwise increments.
  - On reaching `DEBOUNCE_CICLOS`, `botao_limpo` toggles and the counter clears.
  - Emits one-cycle `borda_subida` / `borda_descida` pulses on each toggle.
- FSM states: OCIOSO, ESPERA_PRESSAO, ESPERA_SOLTURA, CONCLUIDO.
  - OCIOSO: if `ctrl_entrada`=1 → ESPERA_PRESSAO.
  - ESPERA_PRESSAO:
    - on `borda_subida`: load the synchronized `chaves` into the capture register → ESPERA_SOLTURA.
    - if `ctrl_entrada`=0 (flush): → OCIOSO with the register unchanged.
    - Capture has priority when both happen in the same cycle.
  - ESPERA_SOLTURA: on `borda_descida` → CONCLUIDO. `ctrl_entrada` is ignored in this state.
  - CONCLUIDO: → OCIOSO unconditionally.
- Button already held when entering ESPERA_PRESSAO: it is not a press. Only a fresh debounced rising edge captures, so a release followed by a new press is required.
- `pausa` is combinational:
  - (state=OCIOSO and `ctrl_entrada`) or state ∈ {ESPERA_PRESSAO, ESPERA_SOLTURA}.
  - It is 0 in CONCLUIDO.
- `dado_valido` = (state=CONCLUIDO).
- `entrada_dados` = {(32−LARGURA_CHAVES) zeros, capture register}. It holds its value between captures.
- Back-to-back input instructions: `ctrl_entrada` high in the OCIOSO cycle after CONCLUIDO starts a new capture. That is correct, because the PC has advanced.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - state OCIOSO, capture register 0, synchronizers 0, `botao_limpo` 0, counter 0.
  - Outputs: `entrada_dados`=0, `pausa`=`ctrl_entrada`, `dado_valido`=0.
- Reset mid-capture aborts the capture. No `dado_valido` is produced.
- Button latency: 2 sync cycles + `DEBOUNCE_CICLOS` cycles from a raw level change to the edge pulse.
- The edge pulse and the state transition happen in the same clock cycle.
- `entrada_dados` updates in the cycle the FSM enters ESPERA_SOLTURA. It is stable in CONCLUIDO.
- Minimum stall: `pausa` is high from the decode cycle until CONCLUIDO.
  - Decode cycle + ≥(2+`DEBOUNCE_CICLOS`) cycles for the press + ≥(2+`DEBOUNCE_CICLOS`) cycles for the release.
- Counter width: $clog2(`DEBOUNCE_CICLOS`+1). The counter never wraps.
- Glitches shorter than `DEBOUNCE_CICLOS` produce no edge.

## Structure
- Package `pkg_entrada_dados`:
  - state typedef and encodings (OCIOSO=2'b00, ESPERA_PRESSAO=2'b01, ESPERA_SOLTURA=2'b10, CONCLUIDO=2'b11);
  - default `DEBOUNCE_CICLOS`.
- Sub-module `filtro_botao`:
  - 2-FF synchronizer + debounce counter;
  - outputs `botao_limpo`, `borda_subida`, `borda_descida`;
  - parameterized by `DEBOUNCE_CICLOS`.
- Top level holds the switch synchronizer, the FSM and the capture register.

## Test plan
All scenarios use `DEBOUNCE_CICLOS`=4.
- Reset: `reset_n`=0 asynchronously mid-clock → `entrada_dados`=0, `dado_valido`=0, state OCIOSO immediately. `pausa`=`ctrl_entrada`.
- Basic capture:
  - Stimulus: `chaves`=16'hA5C3, `ctrl_entrada`=1, button pressed 20 cycles, then released.
  - Response: `pausa`=1 from the decode cycle through release; `entrada_dados`=32'h0000A5C3 after the press edge; `dado_valido` pulses exactly once; `pausa`=0 in that cycle.
- Bounce:
  - Stimulus: button toggles every 2 cycles for 30 cycles, then held at 1.
  - Response: exactly one capture, 2+4 cycles after the final rising transition; no early `dado_valido`.
- Held button: button already held at 1 when `ctrl_entrada` rises → no capture until released ≥4 cycles and pressed again.
- Switches changing:
  - Stimulus: `chaves` changes 16'h0001 → 16'hFFFF after the press edge.
  - Response: `entrada_dados` stays 32'h00000001.
- Flush / back-to-back:
  - `ctrl_entrada` dropped in ESPERA_PRESSAO → OCIOSO, `pausa`=0, register unchanged.
  - Two consecutive input instructions → two separate stalls and two `dado_valido` pulses.
